// File: rtl/kairo_lsu.sv
// kairo load/store unit: one data-memory access per request over a
// valid/ready bus, with byte-lane alignment, load extension and error flags.
module kairo_lsu #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        INST_LB,
  input  logic        INST_LH,
  input  logic        INST_LW,
  input  logic        INST_LBU,
  input  logic        INST_LHU,
  input  logic        INST_SB,
  input  logic        INST_SH,
  input  logic        INST_SW,
  input  logic [31:0] ADDR,
  input  logic [31:0] WDATA,
  output logic        D_MEM_VALID,
  input  logic        D_MEM_READY,
  output logic [31:0] D_MEM_ADDR,
  output logic [3:0]  D_MEM_WSTB,
  output logic [31:0] D_MEM_WDATA,
  input  logic [31:0] D_MEM_RDATA,
  output logic        DONE,
  output logic        RD_WE,
  output logic [31:0] RDATA,
  output logic        ERR_MISALIGN,
  output logic        ERR_BUS
);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    FIN
  } state_t;

  typedef enum logic [2:0] {
    OP_LB,
    OP_LH,
    OP_LW,
    OP_LBU,
    OP_LHU,
    OP_SB,
    OP_SH,
    OP_SW
  } op_t;

  localparam logic [31:0] TO = 32'(TIMEOUT_CYCLES);

  state_t      state;
  op_t         op_q;
  logic [1:0]  a_q;
  logic [31:0] cnt;

  op_t         dec_op;
  logic        dec_hit;
  logic        dec_mis;
  logic [3:0]  st_wstb;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;
  logic        op_load;

  // Several type bits at once resolve in load-first order.
  always_comb begin
    dec_hit = 1'b1;
    dec_op  = OP_LB;
    priority case (1'b1)
      INST_LB:  dec_op = OP_LB;
      INST_LH:  dec_op = OP_LH;
      INST_LW:  dec_op = OP_LW;
      INST_LBU: dec_op = OP_LBU;
      INST_LHU: dec_op = OP_LHU;
      INST_SB:  dec_op = OP_SB;
      INST_SH:  dec_op = OP_SH;
      INST_SW:  dec_op = OP_SW;
      default:  dec_hit = 1'b0;
    endcase
  end

  always_comb begin
    dec_mis = 1'b0;
    unique case (dec_op)
      OP_LH, OP_LHU, OP_SH: dec_mis = ADDR[0];
      OP_LW, OP_SW:         dec_mis = |ADDR[1:0];
      default:              dec_mis = 1'b0;
    endcase
  end

  always_comb begin
    st_wstb  = 4'b0000;
    st_wdata = 32'd0;
    unique case (dec_op)
      OP_SB: begin
        st_wstb  = 4'b0001 << ADDR[1:0];
        st_wdata = {4{WDATA[7:0]}};
      end
      OP_SH: begin
        st_wstb  = ADDR[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{WDATA[15:0]}};
      end
      OP_SW: begin
        st_wstb  = 4'b1111;
        st_wdata = WDATA;
      end
      default: begin
        st_wstb  = 4'b0000;
        st_wdata = 32'd0;
      end
    endcase
  end

  always_comb begin
    ld_byte = D_MEM_RDATA[7:0];
    unique case (a_q)
      2'd0:    ld_byte = D_MEM_RDATA[7:0];
      2'd1:    ld_byte = D_MEM_RDATA[15:8];
      2'd2:    ld_byte = D_MEM_RDATA[23:16];
      default: ld_byte = D_MEM_RDATA[31:24];
    endcase
  end

  assign ld_half = a_q[1] ? D_MEM_RDATA[31:16]
                          : D_MEM_RDATA[15:0];

  always_comb begin
    ld_val  = 32'd0;
    op_load = 1'b1;
    unique case (op_q)
      OP_LB:   ld_val = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_val = {24'd0, ld_byte};
      OP_LH:   ld_val = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_val = {16'd0, ld_half};
      OP_LW:   ld_val = D_MEM_RDATA;
      default: begin
        ld_val  = 32'd0;
        op_load = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      op_q         <= OP_LB;
      a_q          <= 2'd0;
      cnt          <= 32'd0;
      REQ_READY    <= 1'b1;
      D_MEM_VALID  <= 1'b0;
      D_MEM_ADDR   <= 32'd0;
      D_MEM_WSTB   <= 4'b0000;
      D_MEM_WDATA  <= 32'd0;
      DONE         <= 1'b0;
      RD_WE        <= 1'b0;
      RDATA        <= 32'd0;
      ERR_MISALIGN <= 1'b0;
      ERR_BUS      <= 1'b0;
    end else begin
      DONE         <= 1'b0;
      RD_WE        <= 1'b0;
      RDATA        <= 32'd0;
      ERR_MISALIGN <= 1'b0;
      ERR_BUS      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (REQ_VALID && dec_hit) begin
            op_q      <= dec_op;
            a_q       <= ADDR[1:0];
            cnt       <= 32'd0;
            REQ_READY <= 1'b0;
            if (dec_mis) begin
              state        <= FIN;
              DONE         <= 1'b1;
              ERR_MISALIGN <= 1'b1;
            end else begin
              state       <= BUS;
              D_MEM_VALID <= 1'b1;
              D_MEM_ADDR  <= {ADDR[31:2], 2'b00};
              D_MEM_WSTB  <= st_wstb;
              D_MEM_WDATA <= st_wdata;
            end
          end
        end
        BUS: begin
          // READY on the limit cycle still completes normally.
          if (D_MEM_READY) begin
            state       <= FIN;
            D_MEM_VALID <= 1'b0;
            DONE        <= 1'b1;
            RD_WE       <= op_load;
            RDATA       <= ld_val;
          end else if (TO != 32'd0 && cnt + 32'd1 == TO) begin
            state       <= FIN;
            D_MEM_VALID <= 1'b0;
            DONE        <= 1'b1;
            ERR_BUS     <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        FIN: begin
          state     <= IDLE;
          REQ_READY <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          REQ_READY <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kairo_lsu.sv
// Bench for kairo_lsu: fixed vectors, priority/reset/ignore sequences
// and randomized accesses against a size/offset reference model.
module tb_kairo_lsu;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic        INST_LB = 1'b0, INST_LH = 1'b0, INST_LW = 1'b0;
  logic        INST_LBU = 1'b0, INST_LHU = 1'b0;
  logic        INST_SB = 1'b0, INST_SH = 1'b0, INST_SW = 1'b0;
  logic [31:0] ADDR = 32'd0;
  logic [31:0] WDATA = 32'd0;
  logic        D_MEM_VALID;
  logic        D_MEM_READY = 1'b0;
  logic [31:0] D_MEM_ADDR;
  logic [3:0]  D_MEM_WSTB;
  logic [31:0] D_MEM_WDATA;
  logic [31:0] D_MEM_RDATA = 32'd0;
  logic        DONE;
  logic        RD_WE;
  logic [31:0] RDATA;
  logic        ERR_MISALIGN;
  logic        ERR_BUS;

  kairo_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .INST_LB(INST_LB), .INST_LH(INST_LH), .INST_LW(INST_LW),
    .INST_LBU(INST_LBU), .INST_LHU(INST_LHU),
    .INST_SB(INST_SB), .INST_SH(INST_SH), .INST_SW(INST_SW),
    .ADDR(ADDR), .WDATA(WDATA),
    .D_MEM_VALID(D_MEM_VALID), .D_MEM_READY(D_MEM_READY),
    .D_MEM_ADDR(D_MEM_ADDR), .D_MEM_WSTB(D_MEM_WSTB),
    .D_MEM_WDATA(D_MEM_WDATA), .D_MEM_RDATA(D_MEM_RDATA),
    .DONE(DONE), .RD_WE(RD_WE), .RDATA(RDATA),
    .ERR_MISALIGN(ERR_MISALIGN), .ERR_BUS(ERR_BUS)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]  inst;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] mem;
    int          delay;
    logic [31:0] eaddr;
    logic [3:0]  ewstb;
    logic [31:0] ewdata;
    logic [31:0] erdata;
    logic        erdwe;
    logic        emis;
    logic        ebus;
    logic        chkw;
    int          evc;
    int          edone;
  } vec_t;

  typedef struct {
    int          vcyc;
    int          done;
    bit          timed_out;
    bit          stable;
    logic [31:0] addr;
    logic [3:0]  wstb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rdwe;
    logic        mis;
    logic        bus;
  } obs_t;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_inst(input logic [7:0] i);
    {INST_SW, INST_SH, INST_SB, INST_LHU,
     INST_LBU, INST_LW, INST_LH, INST_LB} = i;
  endtask

  function automatic vec_t mkv(
    input logic [7:0] inst, input logic [31:0] addr, wd, mem,
    input int delay, input logic [3:0] ewstb,
    input logic [31:0] ewdata, erdata, input logic erdwe, emis, ebus,
    input int evc, edone);
    vec_t v;
    v.inst = inst; v.addr = addr; v.wd = wd; v.mem = mem;
    v.delay = delay; v.eaddr = {addr[31:2], 2'b00};
    v.ewstb = ewstb; v.ewdata = ewdata; v.erdata = erdata;
    v.erdwe = erdwe; v.emis = emis; v.ebus = ebus;
    v.chkw = (inst[7:5] != 3'b000) && (inst[4:0] == 5'b0);
    v.evc = evc; v.edone = edone;
    return v;
  endfunction

  // Reference: op index 0..7 = LB,LH,LW,LBU,LHU,SB,SH,SW.
  function automatic vec_t model(input int op, input logic [31:0] addr,
                                 wd, mem, input int delay);
    vec_t   v;
    int     sz, off;
    bit     st, sgn;
    longint val;
    sz  = (op == 0 || op == 3 || op == 5) ? 1 :
          (op == 1 || op == 4 || op == 6) ? 2 : 4;
    st  = op >= 5;
    sgn = op <= 1;
    off = int'(addr % 4);
    v.inst = 8'(1 << op); v.addr = addr; v.wd = wd; v.mem = mem;
    v.delay = delay;
    v.eaddr = addr & 32'hFFFF_FFFC;
    v.emis = (off % sz) != 0;
    v.evc = v.emis ? 0 : (delay < TO ? delay + 1 : TO);
    v.ebus = !v.emis && delay >= TO;
    v.edone = v.emis ? 1 : v.evc + 1;
    v.ewstb = st ? 4'(((1 << sz) - 1) << off) : 4'b0;
    v.chkw = st;
    for (int i = 0; i < 4; i++)
      v.ewdata[8*i +: 8] = 8'(wd >> (8 * (i % sz)));
    val = (longint'(mem) >> (8 * off)) & ((64'd1 << (8 * sz)) - 1);
    if (sgn && ((val >> (8 * sz - 1)) & 1) == 1)
      val = val - (64'sd1 << (8 * sz));
    v.erdwe = !st && !v.emis && !v.ebus;
    v.erdata = v.erdwe ? 32'(val) : 32'd0;
    return v;
  endfunction

  task automatic run(input logic [7:0] inst, input logic [31:0] addr,
                     wd, mem, input int delay, input bit poke,
                     output obs_t o);
    int cyc, vc;
    bit fin;
    o = '{default: 0};
    o.stable = 1;
    @(negedge CLK);
    REQ_VALID = 1'b1; set_inst(inst); ADDR = addr; WDATA = wd;
    @(posedge CLK); #1;
    REQ_VALID = poke;
    set_inst(poke ? 8'h04 : 8'h00);
    ADDR = $urandom; WDATA = $urandom;
    cyc = 0; vc = 0; fin = 0;
    while (!fin && cyc < 20) begin
      @(negedge CLK);
      cyc++;
      if (D_MEM_VALID) begin
        vc++;
        if (vc == 1) begin
          o.addr = D_MEM_ADDR; o.wstb = D_MEM_WSTB;
          o.wdata = D_MEM_WDATA;
        end else if (D_MEM_ADDR !== o.addr || D_MEM_WSTB !== o.wstb ||
                     D_MEM_WDATA !== o.wdata) begin
          o.stable = 0;
        end
        D_MEM_READY = (vc - 1 == delay);
        D_MEM_RDATA = (vc - 1 == delay) ? mem : $urandom;
      end else begin
        D_MEM_READY = 1'b0;
      end
      if (DONE) begin
        fin = 1; o.done = cyc; o.rdata = RDATA; o.rdwe = RD_WE;
        o.mis = ERR_MISALIGN; o.bus = ERR_BUS;
        REQ_VALID = 1'b0; set_inst(8'h00);
      end
    end
    REQ_VALID = 1'b0; set_inst(8'h00); D_MEM_READY = 1'b0;
    o.vcyc = vc;
    o.timed_out = !fin;
  endtask

  task automatic compare(input string tag, input vec_t v, input obs_t o);
    if (o.timed_out) begin
      tests++; fails++;
      $display("FAIL %s.done: got no DONE expected DONE", tag);
    end else begin
      chk({tag, ".vcyc"}, o.vcyc, v.evc);
      chk({tag, ".lat"}, o.done, v.edone);
      if (v.evc > 0) begin
        chk({tag, ".addr"}, o.addr, v.eaddr);
        chk({tag, ".wstb"}, 32'(o.wstb), 32'(v.ewstb));
        chk({tag, ".stable"}, 32'(o.stable), 32'd1);
        if (v.chkw) chk({tag, ".wdata"}, o.wdata, v.ewdata);
      end
      chk({tag, ".rdata"}, o.rdata, v.erdata);
      chk({tag, ".rdwe"}, 32'(o.rdwe), 32'(v.erdwe));
      chk({tag, ".mis"}, 32'(o.mis), 32'(v.emis));
      chk({tag, ".bus"}, 32'(o.bus), 32'(v.ebus));
    end
  endtask

  initial begin
    vec_t vt[$];
    vec_t v;
    obs_t o;
    int   n;

    vt.push_back(mkv(8'h80, 32'h1000_0004, 32'hDEAD_BEEF, 0, 0,
      4'b1111, 32'hDEAD_BEEF, 0, 0, 0, 0, 1, 2));
    vt.push_back(mkv(8'h20, 32'h1000_0003, 32'h0000_00A5, 0, 0,
      4'b1000, 32'hA5A5_A5A5, 0, 0, 0, 0, 1, 2));
    vt.push_back(mkv(8'h40, 32'h1000_0002, 32'h0000_1234, 0, 0,
      4'b1100, 32'h1234_1234, 0, 0, 0, 0, 1, 2));
    vt.push_back(mkv(8'h01, 32'h2000_0003, 0, 32'h80FF_7F01, 0,
      4'b0000, 0, 32'hFFFF_FF80, 1, 0, 0, 1, 2));
    vt.push_back(mkv(8'h08, 32'h2000_0003, 0, 32'h80FF_7F01, 0,
      4'b0000, 0, 32'h0000_0080, 1, 0, 0, 1, 2));
    vt.push_back(mkv(8'h02, 32'h2000_0002, 0, 32'h80FF_7F01, 0,
      4'b0000, 0, 32'hFFFF_80FF, 1, 0, 0, 1, 2));
    vt.push_back(mkv(8'h10, 32'h2000_0000, 0, 32'h80FF_7F01, 0,
      4'b0000, 0, 32'h0000_7F01, 1, 0, 0, 1, 2));
    vt.push_back(mkv(8'h04, 32'h2000_0000, 0, 32'h80FF_7F01, 0,
      4'b0000, 0, 32'h80FF_7F01, 1, 0, 0, 1, 2));
    vt.push_back(mkv(8'h04, 32'h2000_0002, 0, 32'h80FF_7F01, 0,
      4'b0000, 0, 0, 0, 1, 0, 0, 1));
    vt.push_back(mkv(8'h02, 32'h2000_0001, 0, 32'h80FF_7F01, 0,
      4'b0000, 0, 0, 0, 1, 0, 0, 1));
    vt.push_back(mkv(8'h80, 32'h3000_0010, 32'h1111_2222, 0, 99,
      4'b1111, 32'h1111_2222, 0, 0, 0, 1, 4, 5));
    vt.push_back(mkv(8'h04, 32'h3000_0010, 0, 32'hCAFE_F00D, 3,
      4'b0000, 0, 32'hCAFE_F00D, 1, 0, 0, 4, 5));
    vt.push_back(mkv(8'h20, 32'h3000_0001, 32'h0000_003C, 0, 1,
      4'b0010, 32'h3C3C_3C3C, 0, 0, 0, 0, 2, 3));
    vt.push_back(mkv(8'h81, 32'h2000_0003, 32'hFFFF_FFFF,
      32'h80FF_7F01, 0, 4'b0000, 0, 32'hFFFF_FF80, 1, 0, 0, 1, 2));
    vt.push_back(mkv(8'h0A, 32'h2000_0002, 0, 32'h80FF_7F01, 0,
      4'b0000, 0, 32'hFFFF_80FF, 1, 0, 0, 1, 2));

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst.req_ready", 32'(REQ_READY), 32'd1);
    chk("rst.valid", 32'(D_MEM_VALID), 32'd0);
    chk("rst.addr", D_MEM_ADDR, 32'd0);
    chk("rst.wstb", 32'(D_MEM_WSTB), 32'd0);
    chk("rst.wdata", D_MEM_WDATA, 32'd0);
    chk("rst.done", {29'd0, DONE, RD_WE, ERR_BUS}, 32'd0);
    chk("rst.rdata", RDATA, 32'd0);
    chk("rst.mis", 32'(ERR_MISALIGN), 32'd0);
    RST = 1'b0;

    foreach (vt[i]) begin
      run(vt[i].inst, vt[i].addr, vt[i].wd, vt[i].mem, vt[i].delay, 0, o);
      compare($sformatf("vec%0d", i), vt[i], o);
    end

    // REQ_VALID with no type bit: nothing happens.
    @(negedge CLK);
    REQ_VALID = 1'b1; set_inst(8'h00); ADDR = 32'h40;
    n = 0;
    repeat (4) begin
      @(negedge CLK);
      if (D_MEM_VALID || DONE || !REQ_READY) n++;
    end
    REQ_VALID = 1'b0;
    chk("notype.ignored", n, 0);

    // A second request while in BUS/FIN is not accepted.
    v = model(5, 32'h5000_0002, 32'h0000_0077, 32'd0, 2);
    run(v.inst, v.addr, v.wd, v.mem, v.delay, 1, o);
    compare("poke", v, o);
    n = 0;
    repeat (4) begin
      @(negedge CLK);
      if (D_MEM_VALID || DONE) n++;
    end
    chk("poke.no_extra", n, 0);
    chk("poke.req_ready", 32'(REQ_READY), 32'd1);

    // Reset in the middle of a stalled bus cycle.
    @(negedge CLK);
    REQ_VALID = 1'b1; set_inst(8'h80); ADDR = 32'h20; WDATA = 32'h5;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0; set_inst(8'h00); D_MEM_READY = 1'b0;
    @(negedge CLK);
    chk("rstmid.valid1", 32'(D_MEM_VALID), 32'd1);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("rstmid.valid", 32'(D_MEM_VALID), 32'd0);
    chk("rstmid.req_ready", 32'(REQ_READY), 32'd1);
    chk("rstmid.done", 32'(DONE), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    n = 0;
    repeat (4) begin
      @(negedge CLK);
      if (DONE || D_MEM_VALID) n++;
    end
    chk("rstmid.quiet", n, 0);

    for (int i = 0; i < 60; i++) begin
      int op;
      op = int'($urandom_range(0, 7));
      v = model(op, $urandom, $urandom, $urandom,
                int'($urandom_range(0, 6)));
      run(v.inst, v.addr, v.wd, v.mem, v.delay, 0, o);
      compare($sformatf("rnd%0d", i), v, o);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/kairo_lsu.md
Name: kairo_lsu

Overview:
- Load/store unit for the kairo core; receives the effective address and store data computed by the ALU stage.
- Performs the data-memory access over a valid/ready bus, aligning byte lanes on stores.
- Extracts and sign/zero-extends load data and returns the writeback value with a done pulse.
- Flags misaligned accesses and bus timeouts instead of issuing or completing them.

Parameters:
TIMEOUT_CYCLES, 256, number of cycles D_MEM_VALID may stay high without D_MEM_READY before a bus error is raised; 0 disables the timeout.

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  synchronous active-high reset
REQ_VALID  input  1  request strobe, sampled only when REQ_READY=1
REQ_READY  output  1  high in IDLE only
INST_LB, INST_LH, INST_LW, INST_LBU, INST_LHU, INST_SB, INST_SH, INST_SW  input  1 each  decoded access type, qualified by REQ_VALID
ADDR  input  32  effective byte address (ALU sum RS1+IMM)
WDATA  input  32  store source (RS2)
D_MEM_VALID  output  1  bus request
D_MEM_READY  input  1  bus accept/complete
D_MEM_ADDR  output  32  word address {ADDR[31:2],2'b00}
D_MEM_WSTB  output  4  byte write strobes; 0000 = read
D_MEM_WDATA  output  32  lane-replicated store data
D_MEM_RDATA  input  32  read data, valid when D_MEM_VALID&D_MEM_READY
DONE  output  1  one-cycle completion pulse
RD_WE  output  1  =DONE & load & no error
RDATA  output  32  extended load result; 0 for stores/errors
ERR_MISALIGN  output  1  with DONE: access misaligned, no bus cycle issued
ERR_BUS  output  1  with DONE: bus timeout

Behaviour:
- Reset: state IDLE; REQ_READY=1; D_MEM_VALID=0, D_MEM_ADDR=0, D_MEM_WSTB=0, D_MEM_WDATA=0, DONE=0, RD_WE=0, RDATA=0, both ERR=0; timeout counter=0. RST mid-transaction abandons the bus cycle; D_MEM_VALID=0 after that edge.
- FSM states: IDLE, BUS, FIN.
- IDLE: on REQ_VALID with at least one INST_* bit, latch type, ADDR[1:0], and bus fields. Priority if several bits are set: LB>LH>LW>LBU>LHU>SB>SH>SW. REQ_VALID with no type bit is ignored.
- Misalignment: LH/LHU/SH with ADDR[0]=1, or LW/SW with ADDR[1:0]!=0. Next state is FIN with ERR_MISALIGN=1; D_MEM_VALID is never raised.
- Otherwise next state is BUS with D_MEM_VALID=1.
- BUS: D_MEM_VALID, D_MEM_ADDR, D_MEM_WSTB and D_MEM_WDATA are held stable until D_MEM_READY. On D_MEM_VALID&D_MEM_READY: capture D_MEM_RDATA, drop D_MEM_VALID at that edge, go to FIN.
- Timeout: counter increments each BUS cycle without READY. When the counter reaches TIMEOUT_CYCLES, go to FIN with ERR_BUS=1 and drop VALID. READY in the same cycle as the limit wins (normal completion).
- FIN: one cycle with DONE=1, RDATA/RD_WE/ERR valid, then IDLE. REQ_READY=0 in BUS and FIN; requests presented then are not accepted.
- Latency: request at edge k, D_MEM_VALID high cycle k+1. With READY in that cycle, DONE is high in cycle k+2. Misaligned access: DONE in cycle k+1. Back-to-back throughput is one access per 3 cycles minimum.
- Store strobes/data (a = ADDR[1:0]):
  - SB: WSTB = 0001<<a, WDATA = {4{WDATA[7:0]}}.
  - SH: WSTB = a[1] ? 1100 : 0011, WDATA = {2{WDATA[15:0]}}.
  - SW: WSTB = 1111, WDATA = WDATA.
- Loads use WSTB=0000. Lane = RDATA byte a (LB/LBU) or halfword a[1] (LH/LHU).
  - LB/LH: sign-extend to 32 bits.
  - LBU/LHU: zero-extend.
  - LW: pass-through.
- Stores complete with RDATA=0, RD_WE=0. Error completions: RDATA=0, RD_WE=0.
- DONE, RD_WE and ERR_* are 0 in every non-FIN cycle.

Test Plan:
- SW ADDR=0x1000_0004, WDATA=0xDEADBEEF, READY same cycle -> D_MEM_ADDR=0x1000_0004, WSTB=1111, WDATA=0xDEADBEEF; DONE 2 cycles after request, RD_WE=0.
- SB ADDR=...03, WDATA=0x0000_00A5 -> WSTB=1000, D_MEM_WDATA=0xA5A5A5A5. SH ADDR=...02, WDATA=0x1234 -> WSTB=1100, WDATA=0x12341234.
- D_MEM_RDATA=0x80FF7F01:
  - LB @+3 -> 0xFFFFFF80; LBU @+3 -> 0x00000080.
  - LH @+2 -> 0xFFFF80FF; LHU @+0 -> 0x00007F01.
  - LW -> 0x80FF7F01; RD_WE=1 on each.
- LW ADDR=...02 and LH ADDR=...01 -> no D_MEM_VALID, DONE next cycle with ERR_MISALIGN=1, RDATA=0, RD_WE=0.
- TIMEOUT_CYCLES=4, READY held low -> VALID high for exactly 4 cycles, then DONE with ERR_BUS=1. Repeat with READY on the 4th cycle -> normal completion, ERR_BUS=0.
- Stall READY 3 cycles, assert RST in 2nd -> VALID low next edge, no DONE, REQ_READY=1. A new REQ_VALID during BUS is ignored.
